// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_sender among NUM_REQ byte producers, with a transmit watchdog.
// All outputs are registered. send_en rises 1 cycle after req is seen in IDLE, and ack follows tx_done by 1 cycle.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 600000,
  parameter int CNT_W       = 20,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2:0]           baud_cfg,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 send_en,
  output logic [2:0]           baud_set,
  input  logic                 tx_done,
  input  logic                 uart_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [2:0]           baud_q, baud_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 send_en_q, send_en_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     wdog_q, wdog_d, wdog_inc;
  logic                 timeout;
  logic [IDW-1:0]       pick;
  logic                 pick_vld;
  logic [IDW:0]         sum;

  // Scan from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      sum = {1'b0, last_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      if (req[sum[IDW-1:0]]) begin
        pick     = sum[IDW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Compared after this cycle's increment so an abort ack lands TIMEOUT_CYC cycles after send_en.
  assign wdog_inc = wdog_q + CNT_W'(1);
  assign timeout  = (wdog_inc == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= IDW'(NUM_REQ - 1);
      grant_q   <= '0;
      tx_data_q <= 8'h00;
      baud_q    <= 3'd0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      send_en_q <= 1'b0;
      busy_q    <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      baud_q    <= baud_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      send_en_q <= send_en_d;
      busy_q    <= busy_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_LOAD;
      S_LOAD:  state_d = S_WAIT;
      S_WAIT:  if (tx_done || timeout) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d    = last_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    baud_d    = baud_q;
    wdog_d    = wdog_q;
    ack_d     = '0;
    err_d     = 1'b0;
    send_en_d = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        baud_d = baud_cfg;
        if (pick_vld) begin
          grant_d   = pick;
          last_d    = pick;
          tx_data_d = req_data[{pick, 3'b000} +: 8];
          send_en_d = 1'b1;
        end
      end
      S_LOAD: wdog_d = '0;
      S_WAIT: begin
        wdog_d = wdog_inc;
        if (tx_done || timeout) begin
          ack_d[grant_q] = 1'b1;
          err_d          = !tx_done;
        end
      end
      // Reload on the way out so a mid-frame baud change shows on the first IDLE cycle.
      S_ACK:   baud_d = baud_cfg;
      default: ;
    endcase
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign tx_data  = tx_data_q;
  assign send_en  = send_en_q;
  assign baud_set = baud_q;

  a_idle_sender_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !(state_q == S_IDLE && uart_state));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_sender loopback model plus a modulo-search round-robin reference.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [2:0]     baud_cfg;
  logic [N-1:0]   ack;
  logic           err;
  logic [1:0]     grant_id;
  logic           busy;
  logic [7:0]     tx_data;
  logic           send_en;
  logic [2:0]     baud_set;
  logic           tx_done;
  logic           uart_state;

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cyc = -1, idle_viol = 0;
  int frame_len = 12;
  bit hang = 1'b0;
  int ref_last = N - 1;
  int cur_g, cur_b, cur_baud;
  int sc, ac, prev_ac, rc;
  logic [7:0] rx_q[$];
  logic [2:0] rxb_q[$];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .baud_cfg(baud_cfg),
    .ack(ack), .err(err), .grant_id(grant_id), .busy(busy), .tx_data(tx_data),
    .send_en(send_en), .baud_set(baud_set), .tx_done(tx_done), .uart_state(uart_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // uart_sender stand-in: latches byte/baud on send_en, pulses tx_done frame_len cycles later.
  initial begin : sender
    int cnt;
    bit active;
    logic [7:0] b;
    logic [2:0] bd;
    tx_done = 1'b0; uart_state = 1'b0; active = 1'b0; cnt = 0; b = 8'h00; bd = 3'd0;
    forever begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (!rst_n) begin
        active = 1'b0; uart_state = 1'b0;
      end else if (active) begin
        if (cnt <= 1) begin
          tx_done = 1'b1; uart_state = 1'b0; active = 1'b0;
          rx_q.push_back(b); rxb_q.push_back(bd); done_cyc = cyc;
        end else cnt--;
      end else if (send_en === 1'b1 && !hang) begin
        active = 1'b1; uart_state = 1'b1; cnt = frame_len; b = tx_data; bd = baud_set;
      end
      if (uart_state && busy === 1'b0) idle_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int ref_pick(input logic [N-1:0] r, input int last);
    logic [1:0] j;
    for (int k = 1; k <= N; k++) begin
      j = 2'((last + k) % N);
      if (r[j]) return int'(j);
    end
    return 0;
  endfunction

  // Predicts the winner from the current req, waits for send_en, checks grant and byte.
  task automatic pick_and_send(input string tag, output int s);
    logic [31:0] d;
    d        = req_data;
    cur_g    = ref_pick(req, ref_last);
    cur_b    = int'((d >> (8 * cur_g)) & 32'hFF);
    cur_baud = int'(baud_cfg);
    ref_last = cur_g;
    for (int i = 0; i < 8; i++) begin
      if (send_en === 1'b1) break;
      tick();
    end
    s = cyc;
    chk({tag, "_send_en"}, 32'(send_en), 32'd1);
    chk({tag, "_grant"},   32'(grant_id), 32'(cur_g));
    chk({tag, "_tx_data"}, 32'(tx_data),  32'(cur_b));
  endtask

  task automatic wait_ack(input string tag, input bit exp_err, output int a);
    int got;
    for (int i = 0; i < 400; i++) begin
      if (ack !== '0) break;
      tick();
    end
    a = cyc;
    chk({tag, "_ack"}, 32'(ack), 32'(1 << cur_g));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!exp_err) begin
      chk({tag, "_ack_lat"}, 32'(a - done_cyc), 32'd1);
      got = (rx_q.size() > 0) ? int'(rx_q.pop_front()) : -1;
      chk({tag, "_rx_byte"}, 32'(got), 32'(cur_b));
      got = (rxb_q.size() > 0) ? int'(rxb_q.pop_front()) : -1;
      chk({tag, "_rx_baud"}, 32'(got), 32'(cur_baud));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},      32'(ack), 32'd0);
    chk({tag, "_err"},      32'(err), 32'd0);
    chk({tag, "_send_en"},  32'(send_en), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data), 32'd0);
    chk({tag, "_grant"},    32'(grant_id), 32'd0);
    chk({tag, "_baud_set"}, 32'(baud_set), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] fair_b [5];
    int fair_g [5];
    fair_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    fair_g = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; req = '0; req_data = '0; baud_cfg = 3'd4;
    tick(3);
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;
    tick(2);

    // Single request with latency checks.
    req_data[7:0] = 8'hAA; req = 4'b0001; rc = cyc;
    pick_and_send("single", sc);
    chk("single_req_lat", 32'(sc - rc), 32'd1);
    wait_ack("single", 1'b0, ac);
    req = '0;
    tick();
    chk("single_busy_after", 32'(busy), 32'd0);

    // Grant 2, then 0101 must wrap to requester 0.
    req_data = 32'h00_5C_00_3C; req = 4'b0100;
    pick_and_send("rot_a", sc);
    wait_ack("rot_a", 1'b0, ac);
    req = 4'b0101;
    pick_and_send("rot_b", sc);
    chk("rot_b_is_0", 32'(grant_id), 32'd0);
    wait_ack("rot_b", 1'b0, ac);
    req = '0;
    tick();

    // Hung transmitter: abort ack+err exactly TO cycles after send_en.
    hang = 1'b1; req_data = 32'hE7_00_00_00; req = 4'b1000;
    pick_and_send("tmo", sc);
    wait_ack("tmo", 1'b1, ac);
    chk("tmo_latency", 32'(ac - sc), 32'(TO));
    req = '0; hang = 1'b0;
    tick();
    chk("tmo_busy_after", 32'(busy), 32'd0);
    chk("tmo_no_rx", 32'(rx_q.size()), 32'd0);

    // Fairness with all requesters held high.
    req_data = 32'h44_33_22_11; req = 4'b1111; frame_len = 5; prev_ac = -1;
    for (int k = 0; k < 5; k++) begin
      pick_and_send("fair", sc);
      chk("fair_order", 32'(grant_id), 32'(fair_g[k]));
      chk("fair_byte", 32'(tx_data), 32'(fair_b[k]));
      if (prev_ac >= 0) chk("fair_gap", 32'(sc - prev_ac), 32'd2);
      wait_ack("fair", 1'b0, ac);
      prev_ac = ac;
      if (k == 4) req = '0;
    end
    tick();

    // Baud change mid-frame stays frozen until back in IDLE.
    frame_len = 10; req_data = 32'h00_00_5A_00; req = 4'b0010;
    pick_and_send("baud_a", sc);
    chk("baud_a_start", 32'(baud_set), 32'd4);
    baud_cfg = 3'd2;
    tick(3);
    chk("baud_frozen", 32'(baud_set), 32'd4);
    wait_ack("baud_a", 1'b0, ac);
    chk("baud_frozen_ack", 32'(baud_set), 32'd4);
    req = '0;
    tick();
    chk("baud_idle_new", 32'(baud_set), 32'd2);
    req_data = 32'h00_A5_00_00; req = 4'b0100;
    pick_and_send("baud_b", sc);
    wait_ack("baud_b", 1'b0, ac);
    req = '0;
    tick();

    // Randomized traffic: new request set on each ack cycle, occasional mid-frame drop.
    req = 4'($urandom_range(1, 15)); req_data = $urandom; frame_len = $urandom_range(1, 15);
    for (int it = 0; it < 24; it++) begin
      pick_and_send("rand", sc);
      if ($urandom_range(0, 3) == 0) req = '0;
      wait_ack("rand", 1'b0, ac);
      if (it == 23) req = '0;
      else begin
        req = 4'($urandom_range(1, 15)); req_data = $urandom;
        baud_cfg = 3'($urandom_range(0, 7)); frame_len = $urandom_range(1, 15);
      end
    end
    tick(2);

    // Reset during WAIT_DONE: immediate reset values, no ack, pointer restarts.
    frame_len = 20; req_data = 32'h00_00_00_C3; req = 4'b0001;
    pick_and_send("rst_mid", sc);
    req = '0;
    tick(3);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    tick(3);
    chk("rst_hold_ack", 32'(ack), 32'd0);
    chk("rst_no_rx", 32'(rx_q.size()), 32'd0);
    #2 rst_n = 1'b1;
    ref_last = N - 1;
    tick();
    frame_len = 6; req_data = 32'h00_00_96_00; req = 4'b0010;
    pick_and_send("after_rst", sc);
    wait_ack("after_rst", 1'b0, ac);
    req = '0;
    tick();
    chk("after_rst_busy", 32'(busy), 32'd0);

    chk("uart_state_in_idle", 32'(idle_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_sender among NUM_REQ byte-producing requesters.
- Sits between the requesters and uart_sender. Drives its data, send_en and baud_set inputs; consumes its tx_done and uart_state outputs.
- Returns a one-cycle ack, plus an error flag, to the requester whose byte was sent.
- Adds a watchdog so a hung transmitter cannot lock the bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); index width IDW = clog2(NUM_REQ).
- TIMEOUT_CYC, 600000, clk cycles allowed in WAIT_DONE before abort (covers one 10-bit frame at 9600 baud, 50 MHz).
- CNT_W, 20, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester level request; that requester's byte must be held stable while its bit is high.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- baud_cfg  in  3  desired baud code; applied only in IDLE.
- ack  out  NUM_REQ  one-cycle pulse to the serviced requester.
- err  out  1  one-cycle pulse with ack when the byte was aborted by timeout.
- grant_id  out  IDW  index of the requester currently owning the sender.
- busy  out  1  high whenever state is not IDLE.
- tx_data  out  8  to uart_sender data.
- send_en  out  1  to uart_sender send_en; one-cycle pulse.
- baud_set  out  3  to uart_sender baud_set.
- tx_done  in  1  from uart_sender; one-cycle pulse at end of frame.
- uart_state  in  1  from uart_sender; high while a frame is in progress.

Behaviour:
- Reset values (asynchronous, active while rst_n=0): state=IDLE; ack, err, send_en = 0; tx_data = 8'h00; grant_id = 0; baud_set = 3'd0; busy = 0; watchdog = 0; round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - Every cycle: baud_set <= baud_cfg.
  - If req != 0, pick the first set bit searching from index last+1, wrapping modulo NUM_REQ.
  - Latch grant_id, tx_data <= req_data[grant]; set last <= grant.
  - Go to LOAD.
  - If req == 0, stay in IDLE.
- LOAD (exactly one cycle): send_en = 1; watchdog cleared; go to WAIT_DONE.
- WAIT_DONE:
  - send_en = 0; watchdog increments each cycle.
  - If tx_done = 1, go to ACK with err_pending = 0.
  - Otherwise, if watchdog == TIMEOUT_CYC-1, go to ACK with err_pending = 1.
  - If tx_done and the timeout coincide, tx_done wins (err = 0).
- ACK (exactly one cycle): ack[grant_id] = 1; err = err_pending; go to IDLE.
- baud_set is frozen from leaving IDLE until returning to IDLE. A baud_cfg change mid-frame takes effect on the first IDLE cycle afterwards.
- Request latency: req seen in IDLE at edge N gives send_en high in cycle N+1. ack follows one cycle after tx_done is sampled. There are 2 dead cycles (ACK, IDLE) between consecutive send_en pulses.
- A requester keeping req high after its ack is treated as a new request. The requester must update req_data on the ack cycle; the arbiter samples it in the following IDLE cycle.
- Round-robin fairness: with all req bits high, grants go 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- The arbiter ignores req changes outside IDLE. A requester dropping req mid-frame still receives ack for the byte already latched.
- uart_state is used for assertion only. It must not be 1 in IDLE; a bench checker flags that case, and the RTL takes no action.
- Reset mid-operation: the in-flight byte is abandoned, no ack or err is issued, state returns to IDLE, and the pointer resets.
- Implementation uses a one-hot or binary encoded 4-state FSM (IDLE, LOAD, WAIT_DONE, ACK), a priority rotate for round-robin selection, and a CNT_W-bit watchdog.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hAA, baud_cfg=4. Required: one send_en pulse with tx_data=8'hAA; receiver loopback yields 8'hAA; ack=4'b0001 one cycle after tx_done; err=0; busy low afterwards.
- Fairness: req=4'b1111 held, bytes 8'h11/22/33/44. Required: grant order 0,1,2,3,0; received byte sequence 11,22,33,44,11.
- Priority rotation: grant 2 completes, then req=4'b0101. Required: requester 0 is served next (search starts at 3, wraps to 0).
- Baud freeze: change baud_cfg 4→2 mid-frame. Required: baud_set stays 4 until the ACK→IDLE transition, then reads 2; next frame uses baud 2.
- Timeout: TIMEOUT_CYC=100, tx_done tied 0. Required: ack and err pulse together exactly 100 cycles after the send_en cycle; state returns to IDLE.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE. Required: all outputs take reset values immediately with no ack pulse; after release, req=4'b0010 is serviced normally.
